spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_reg_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI command/data register file driving a prescaled LED blinker
module spi_reg_ctrl #(
    parameter int PRESCALE = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [7:0] rxd_out,
    input  logic       rxd_flag,
    output logic [7:0] txd_data,
    output logic       led,
    output logic       frame_active
);
    localparam int TW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t          state_q, state_d;
    logic            cs_s1_q, cs_s2_q;
    logic [3:0]      addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [7:0]      txd_q, txd_d, rd_val;
    logic [1:0]      ctrl_q;
    logic [7:0]      per_l_q, per_h_q, scratch_q;
    logic            err_q, led_q;
    logic [TW-1:0]   tick_q;
    logic [15:0]     hp_q;

    // The end-of-frame event is seen as the synchronised cs is about to rise,
    // so a byte arriving in that same clk is still accepted and processed.
    logic        eof, acc, data_acc, wr_en, bad, en, tick;
    logic [15:0] per, per_m1;

    assign eof      = cs_s1_q & ~cs_s2_q;
    assign acc      = rxd_flag & ~cs_s2_q;
    assign data_acc = acc & (state_q == DATA);
    assign wr_en    = data_acc & wr_q;
    assign bad      = data_acc & (addr_q > 4'd5);
    assign en       = ctrl_q[0];
    assign tick     = en & (tick_q == TW'(PRESCALE - 1));
    assign per      = {per_h_q, per_l_q};
    assign per_m1   = (per == 16'd0) ? 16'd0 : per - 16'd1;

    assign txd_data     = txd_q;
    assign led          = led_q;
    assign frame_active = (state_q == DATA);

    // Frame FSM next state: command byte latches addr/direction, data bytes advance addr
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        if (acc) begin
            if (state_q == IDLE) begin
                addr_d  = rxd_out[3:0];
                wr_d    = rxd_out[7];
                state_d = DATA;
            end else begin
                addr_d = addr_q + 4'd1;
            end
        end
        if (eof) state_d = IDLE;
    end

    // Register map read mux, addressed by the post-update address
    always_comb begin
        case (addr_d)
            4'h0:    rd_val = 8'hA5;
            4'h1:    rd_val = {6'b0, ctrl_q};
            4'h2:    rd_val = per_l_q;
            4'h3:    rd_val = per_h_q;
            4'h4:    rd_val = {6'b0, err_q, led_q};
            4'h5:    rd_val = scratch_q;
            default: rd_val = 8'h00;
        endcase
    end

    // Transmit byte: refreshed after every read-frame byte, zero in write frames and IDLE
    always_comb begin
        txd_d = eof ? 8'h00 : acc ? (wr_d ? 8'h00 : rd_val) : txd_q;
    end

    // CS synchroniser and frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s1_q <= 1'b1;
            cs_s2_q <= 1'b1;
            state_q <= IDLE;
            addr_q  <= 4'h0;
            wr_q    <= 1'b0;
            txd_q   <= 8'h00;
        end else begin
            cs_s1_q <= cs;
            cs_s2_q <= cs_s1_q;
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            txd_q   <= txd_d;
        end
    end

    // Writable registers and sticky ERR; a set in the same clk as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= 2'b01;
            per_l_q   <= 8'hF4;
            per_h_q   <= 8'h01;
            scratch_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            if (wr_en && addr_q == 4'h1) ctrl_q <= rxd_out[1:0];
            if (wr_en && addr_q == 4'h2) per_l_q <= rxd_out;
            if (wr_en && addr_q == 4'h3) per_h_q <= rxd_out;
            if (wr_en && addr_q == 4'h5) scratch_q <= rxd_out;
            err_q <= bad | (err_q & ~(wr_en && addr_q == 4'h4 && rxd_out[1]));
        end
    end

    // Blinker: prescaled tick drives a half-period counter; disabled means led follows FORCE
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            hp_q   <= 16'd0;
            led_q  <= 1'b0;
        end else if (!en) begin
            tick_q <= '0;
            hp_q   <= 16'd0;
            led_q  <= ctrl_q[1];
        end else begin
            tick_q <= tick ? '0 : tick_q + TW'(1);
            if (tick) begin
                hp_q  <= (hp_q >= per_m1) ? 16'd0 : hp_q + 16'd1;
                led_q <= (hp_q >= per_m1) ? ~led_q : led_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and randomized frames checked against a behavioural model
module tb_spi_reg_ctrl;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic [7:0] rxd_out = 8'h00;
    logic       rxd_flag = 1'b0;
    logic [7:0] txd_data;
    logic       led, frame_active;

    int n_chk = 0;
    int n_err = 0;

    spi_reg_ctrl #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rxd_out(rxd_out), .rxd_flag(rxd_flag),
        .txd_data(txd_data), .led(led), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    // Model state: register contents, frame position, blink progress, cs history
    logic [7:0] m_reg [0:5];
    bit         m_led, m_err, m_in, m_wr;
    int         m_addr, m_div, m_ticks;
    bit         m_cs_prev1, m_cs_prev2;
    logic [7:0] m_txd;

    function automatic logic [7:0] m_read(int a);
        case (a)
            0:       return 8'hA5;
            1:       return m_reg[1] & 8'h03;
            2, 3, 5: return m_reg[a];
            4:       return {6'b0, m_err, m_led};
            default: return 8'h00;
        endcase
    endfunction

    // Model advances once per clock using the inputs present at the edge
    always @(posedge clk) begin : model
        bit eof, acc, new_led;
        int per;
        if (rst) begin
            m_reg[1] = 8'h01; m_reg[2] = 8'hF4; m_reg[3] = 8'h01; m_reg[5] = 8'h00;
            m_led = 0; m_err = 0; m_in = 0; m_wr = 0; m_addr = 0;
            m_div = 0; m_ticks = 0; m_txd = 8'h00;
            m_cs_prev1 = 1; m_cs_prev2 = 1;
        end else begin
            eof = m_cs_prev1 && !m_cs_prev2;
            acc = rxd_flag && !m_cs_prev2;
            new_led = m_led;
            if (!m_reg[1][0]) begin
                m_div = 0; m_ticks = 0; new_led = m_reg[1][1];
            end else begin
                m_div++;
                if (m_div == P) begin
                    m_div = 0;
                    m_ticks++;
                    per = {m_reg[3], m_reg[2]};
                    if (per == 0) per = 1;
                    if (m_ticks >= per) begin
                        m_ticks = 0;
                        new_led = !m_led;
                    end
                end
            end
            if (acc) begin
                if (!m_in) begin
                    m_addr = int'(rxd_out[3:0]); m_wr = rxd_out[7]; m_in = 1;
                end else begin
                    if (m_addr >= 6) m_err = 1;
                    else if (m_wr) begin
                        if (m_addr == 1) m_reg[1] = rxd_out & 8'h03;
                        else if (m_addr == 4) begin if (rxd_out[1]) m_err = 0; end
                        else if (m_addr != 0) m_reg[m_addr] = rxd_out;
                    end
                    m_addr = (m_addr + 1) % 16;
                end
                m_txd = m_wr ? 8'h00 : m_read(m_addr);
            end
            if (eof) begin m_in = 0; m_txd = 8'h00; end
            m_led = new_led;
            m_cs_prev2 = m_cs_prev1;
            m_cs_prev1 = cs;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            n_chk += 3;
            if (txd_data !== m_txd) begin n_err++; $display("FAIL cyc_txd t=%0t got %h exp %h", $time, txd_data, m_txd); end
            if (led !== m_led) begin n_err++; $display("FAIL cyc_led t=%0t got %b exp %b", $time, led, m_led); end
            if (frame_active !== m_in) begin n_err++; $display("FAIL cyc_fa t=%0t got %b exp %b", $time, frame_active, m_in); end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output logic [7:0] got);
        rxd_out = b; rxd_flag = 1'b1;
        @(negedge clk);
        rxd_flag = 1'b0; got = txd_data;
        @(negedge clk);
    endtask

    task automatic fbegin;
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic fend;
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] g, cmd;
        int nb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_txd", txd_data, 8'h00);
        chk("rst_led", {7'b0, led}, 8'h00);
        chk("rst_fa", {7'b0, frame_active}, 8'h00);
        repeat (1999) @(negedge clk);
        chk("led_before_first_toggle", {7'b0, led}, 8'h00);
        @(negedge clk);
        chk("led_first_toggle", {7'b0, led}, 8'h01);

        fbegin; send(8'h85, g); send(8'h3C, g); send(8'h7E, g);
        chk("fa_in_frame", {7'b0, frame_active}, 8'h01);
        cs = 1'b1;
        @(negedge clk); chk("fa_1clk_after_cs", {7'b0, frame_active}, 8'h01);
        @(negedge clk); chk("fa_2clk_after_cs", {7'b0, frame_active}, 8'h00);
        repeat (2) @(negedge clk);
        fbegin; send(8'h04, g); chk("err_after_reg6", g & 8'h02, 8'h02);
        send(8'h00, g); chk("scratch", g, 8'h3C);
        send(8'h00, g); chk("reg6_reads0", g, 8'h00); fend;

        fbegin;
        send(8'h00, g); chk("rd_id", g, 8'hA5);
        send(8'hFF, g); chk("rd_ctrl", g, 8'h01);
        send(8'hFF, g); chk("rd_perl", g, 8'hF4);
        send(8'hFF, g); chk("rd_perh", g, 8'h01); fend;

        fbegin; send(8'h84, g); send(8'h02, g); chk("wr_frame_txd0", txd_data, 8'h00); fend;
        fbegin; send(8'h04, g); chk("err_cleared", g & 8'h02, 8'h00); fend;
        fbegin; send(8'h8F, g); send(8'h11, g); send(8'h22, g); fend;
        fbegin; send(8'h04, g); chk("err_wrap", g & 8'h02, 8'h02); fend;
        fbegin; send(8'h00, g); chk("id_ro", g, 8'hA5); fend;

        fbegin; send(8'h81, g); send(8'h02, g); fend;
        chk("force_led", {7'b0, led}, 8'h01);
        fbegin; send(8'h82, g); send(8'h03, g); send(8'h00, g); fend;
        repeat (20) @(negedge clk);
        chk("force_led_held", {7'b0, led}, 8'h01);
        fbegin; send(8'h81, g); send(8'h01, g);
        cs = 1'b1;
        repeat (10) @(negedge clk); chk("en_led_before", {7'b0, led}, 8'h01);
        @(negedge clk); chk("en_led_toggle", {7'b0, led}, 8'h00);
        repeat (3) @(negedge clk);

        fbegin; send(8'h85, g);
        cs = 1'b1;
        @(negedge clk);
        send(8'h77, g);
        chk("eof_coincide_fa", {7'b0, frame_active}, 8'h00);
        repeat (3) @(negedge clk);
        fbegin; send(8'h05, g); chk("eof_coincide_byte", g, 8'h77); fend;

        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 7) == 0) send(8'($urandom), g);
            fbegin;
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[3:0] = 4'h4;
            send(cmd, g);
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 24) == 0) begin
                    rst = 1'b1; @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk);
                end
                send(8'($urandom), g);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 4) == 0) begin
                cs = 1'b1; @(negedge clk);
                send(8'($urandom), g);
                repeat (3) @(negedge clk);
            end else fend;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
